// File: rtl/cmp_hazard_ctrl.sv
// ID-stage hazard scheduler: tracks in-flight E/M/W destinations with Tnew
// countdowns, then derives stall and ID operand forwarding selects.
module cmp_hazard_ctrl #(
  parameter int unsigned REG_W  = 5,
  parameter int unsigned TNEW_W = 2,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [TNEW_W-1:0] id_tuse_rs,
  input  logic [TNEW_W-1:0] id_tuse_rt,
  input  logic              id_we,
  input  logic [REG_W-1:0]  id_wreg,
  input  logic [TNEW_W-1:0] id_tnew,
  output logic              stall,
  output logic [1:0]        fwd_sel_rs,
  output logic [1:0]        fwd_sel_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] FWD_GRF = 2'b00;
  localparam logic [1:0] FWD_M   = 2'b01;
  localparam logic [1:0] FWD_W   = 2'b10;
  localparam logic [1:0] FWD_E   = 2'b11;

  logic [REG_W-1:0]  e_reg_q, e_reg_d;
  logic [TNEW_W-1:0] e_tnew_q, e_tnew_d;
  logic [REG_W-1:0]  m_reg_q, m_reg_d;
  logic [TNEW_W-1:0] m_tnew_q, m_tnew_d;
  logic [REG_W-1:0]  w_reg_q, w_reg_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [2:0] res_rs, res_rt;

  // Returns {stall, fwd_sel}; youngest matching stage wins (E > M > W).
  function automatic logic [2:0] resolve(
    input logic [REG_W-1:0]  src,
    input logic              use_src,
    input logic [TNEW_W-1:0] tuse,
    input logic [REG_W-1:0]  er,
    input logic [TNEW_W-1:0] et,
    input logic [REG_W-1:0]  mr,
    input logic [TNEW_W-1:0] mt,
    input logic [REG_W-1:0]  wr
  );
    logic       hit;
    logic [2:0] r;
    hit = use_src && (src != '0);
    r   = {1'b0, FWD_GRF};
    if (hit && (src == er)) begin
      if (et > tuse)       r = {1'b1, FWD_GRF};
      else if (et == '0)   r = {1'b0, FWD_E};
    end else if (hit && (src == mr)) begin
      if (mt > tuse)       r = {1'b1, FWD_GRF};
      else if (mt == '0)   r = {1'b0, FWD_M};
    end else if (hit && (src == wr)) begin
      r = {1'b0, FWD_W};
    end
    return r;
  endfunction

  always_comb begin
    res_rs = resolve(id_rs, id_use_rs, id_tuse_rs, e_reg_q, e_tnew_q, m_reg_q, m_tnew_q, w_reg_q);
    res_rt = resolve(id_rt, id_use_rt, id_tuse_rt, e_reg_q, e_tnew_q, m_reg_q, m_tnew_q, w_reg_q);
    stall      = 1'b0;
    fwd_sel_rs = FWD_GRF;
    fwd_sel_rt = FWD_GRF;
    if (!reset) begin
      stall      = res_rs[2] | res_rt[2];
      fwd_sel_rs = res_rs[1:0];
      fwd_sel_rt = res_rt[1:0];
    end
  end

  // Scoreboard advance; a stall injects an empty bubble into E.
  always_comb begin
    e_reg_d     = e_reg_q;
    e_tnew_d    = e_tnew_q;
    m_reg_d     = m_reg_q;
    m_tnew_d    = m_tnew_q;
    w_reg_d     = w_reg_q;
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      e_reg_d     = '0;
      e_tnew_d    = '0;
      m_reg_d     = '0;
      m_tnew_d    = '0;
      w_reg_d     = '0;
      stall_cnt_d = '0;
    end else begin
      if (stall) begin
        e_reg_d  = '0;
        e_tnew_d = '0;
      end else begin
        e_reg_d  = id_we ? id_wreg : '0;
        e_tnew_d = id_tnew;
      end
      m_reg_d  = e_reg_q;
      m_tnew_d = (e_tnew_q == '0) ? '0 : e_tnew_q - TNEW_W'(1);
      w_reg_d  = m_reg_q;
      if (stall && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    e_reg_q     <= e_reg_d;
    e_tnew_q    <= e_tnew_d;
    m_reg_q     <= m_reg_d;
    m_tnew_q    <= m_tnew_d;
    w_reg_q     <= w_reg_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cmp_hazard_ctrl.sv
// Scenario bench for cmp_hazard_ctrl: expected outputs are queued as each
// ID instruction is driven and popped when the DUT outputs are sampled.
module tb_cmp_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [1:0] trs, trt;
    logic       we;
    logic [4:0] wr;
    logic [1:0] tn;
  } stim_t;

  typedef struct packed {
    logic        st;
    logic [1:0]  frs, frt;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, id_wreg = '0;
  logic        id_use_rs = 1'b0, id_use_rt = 1'b0, id_we = 1'b0;
  logic [1:0]  id_tuse_rs = '0, id_tuse_rt = '0, id_tnew = '0;
  logic        stall, stall_s;
  logic [1:0]  fwd_sel_rs, fwd_sel_rt, fwd_s_rs, fwd_s_rt;
  logic [31:0] stall_cnt;
  logic [1:0]  stall_cnt_sat;

  int total = 0;
  int bad = 0;

  stim_t pend_s[$];
  logic  pend_r[$];
  exp_t  pend_e[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  cmp_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .id_we(id_we), .id_wreg(id_wreg), .id_tnew(id_tnew),
    .stall(stall), .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt),
    .stall_cnt(stall_cnt)
  );

  // Narrow counter copy to reach saturation quickly.
  cmp_hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
    .id_we(id_we), .id_wreg(id_wreg), .id_tnew(id_tnew),
    .stall(stall_s), .fwd_sel_rs(fwd_s_rs), .fwd_sel_rt(fwd_s_rt),
    .stall_cnt(stall_cnt_sat)
  );

  function automatic stim_t op(int rs, int rt, int urs, int urt, int trs, int trt,
                               int we, int wr, int tn);
    stim_t s;
    s.rs = 5'(rs); s.rt = 5'(rt); s.urs = 1'(urs); s.urt = 1'(urt);
    s.trs = 2'(trs); s.trt = 2'(trt); s.we = 1'(we); s.wr = 5'(wr); s.tn = 2'(tn);
    return s;
  endfunction

  function automatic stim_t nop();             return op(0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t lw(int r);         return op(0, 0, 0, 0, 0, 0, 1, r, 2); endfunction
  function automatic stim_t alu(int r);        return op(0, 0, 0, 0, 0, 0, 1, r, 1); endfunction
  function automatic stim_t lui(int r);        return op(0, 0, 0, 0, 0, 0, 1, r, 0); endfunction
  function automatic stim_t beq(int a, int b); return op(a, b, 1, 1, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t jr(int a);         return op(a, 0, 1, 0, 0, 0, 0, 0, 0); endfunction
  function automatic stim_t sw(int b, int d);  return op(b, d, 1, 1, 1, 2, 0, 0, 0); endfunction

  function automatic exp_t ex(int st, int frs, int frt, int cnt);
    exp_t e;
    e.st = 1'(st); e.frs = 2'(frs); e.frt = 2'(frt); e.cnt = 32'(cnt);
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g.st = stall; g.frs = fwd_sel_rs; g.frt = fwd_sel_rt; g.cnt = stall_cnt;
    return g;
  endfunction

  task automatic apply(input stim_t s);
    id_rs = s.rs; id_rt = s.rt; id_use_rs = s.urs; id_use_rt = s.urt;
    id_tuse_rs = s.trs; id_tuse_rt = s.trt; id_we = s.we; id_wreg = s.wr; id_tnew = s.tn;
  endtask

  task automatic add(input logic r, input stim_t s, input exp_t e);
    pend_r.push_back(r); pend_s.push_back(s); pend_e.push_back(e);
  endtask

  // Drive one ID cycle at the falling edge, queue its expectation, settle.
  task automatic drive_next();
    @(negedge clk);
    reset = pend_r.pop_front();
    apply(pend_s.pop_front());
    exp_q.push_back(pend_e.pop_front());
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    apply(nop());
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, g;
    int row = 0;
    add(1, beq(1, 1), ex(0, 0, 0, 0));
    add(1, lw(1),     ex(0, 0, 0, 0));
    add(1, beq(1, 1), ex(0, 0, 0, 0));
    add(0, beq(1, 1), ex(0, 0, 0, 0));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_load_use();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, lw(1),     ex(0, 0, 0, 0));
    add(0, beq(1, 2), ex(1, 0, 0, 0));
    add(0, beq(1, 2), ex(1, 0, 0, 1));
    add(0, beq(1, 2), ex(0, 2, 0, 2));
    add(0, nop(),     ex(0, 0, 0, 2));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL load_use row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_alu_use();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, alu(3),    ex(0, 0, 0, 0));
    add(0, beq(3, 3), ex(1, 0, 0, 0));
    add(0, beq(3, 3), ex(0, 1, 1, 1));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL alu_use row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_e_zero_tnew();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, lui(31), ex(0, 0, 0, 0));
    add(0, jr(31),  ex(0, 3, 0, 0));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL e_zero row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_zero_and_priority();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, lw(0),     ex(0, 0, 0, 0));
    add(0, beq(0, 0), ex(0, 0, 0, 0));
    add(0, alu(5),    ex(0, 0, 0, 0));
    add(0, lui(5),    ex(0, 0, 0, 0));
    add(0, beq(5, 0), ex(0, 3, 0, 0));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL zero_prio row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_late_tuse();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, lw(4),    ex(0, 0, 0, 0));
    add(0, sw(2, 4), ex(0, 0, 0, 0));
    add(0, nop(),    ex(0, 0, 0, 0));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL late_tuse row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, lw(1),     ex(0, 0, 0, 0));
    add(0, beq(1, 2), ex(1, 0, 0, 0));
    add(1, beq(1, 2), ex(0, 0, 0, 1));
    add(0, beq(1, 2), ex(0, 0, 0, 0));
    add(0, beq(1, 2), ex(0, 0, 0, 0));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset_mid row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, g;
    int row = 0;
    do_reset();
    add(0, lw(1),     ex(0, 0, 0, 0));
    add(0, beq(1, 0), ex(1, 0, 0, 0));
    add(0, beq(1, 0), ex(1, 0, 0, 1));
    add(0, beq(1, 0), ex(0, 2, 0, 2));
    add(0, lw(2),     ex(0, 0, 0, 2));
    add(0, beq(2, 2), ex(1, 0, 0, 2));
    add(0, beq(2, 2), ex(1, 0, 0, 3));
    add(0, beq(2, 2), ex(0, 2, 2, 4));
    while (pend_s.size() > 0) begin
      drive_next();
      g = observed(); e = exp_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL back_to_back row%0d: got st=%0b rs=%b rt=%b cnt=%0d want st=%0b rs=%b rt=%b cnt=%0d",
                 row, g.st, g.frs, g.frt, g.cnt, e.st, e.frs, e.frt, e.cnt);
      end
      row++;
    end
    total++;
    if (stall_cnt_sat !== 2'd3) begin
      bad++;
      $display("FAIL saturate: got cnt=%0d want cnt=3", stall_cnt_sat);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_use();
    test_e_zero_tnew();
    test_zero_and_priority();
    test_late_tuse();
    test_reset_mid_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
